// File: rtl/my_design.sv
// Three-tap FIR engine. It reads a job header (N, c0..c2) from the input SRAM,
// streams N samples through a two-stage multiply/sum pipeline, and writes the
// saturated results to the output SRAM at addresses 0..N-1.
module my_design (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        dut_run,
    output logic        dut_busy,
    output logic [11:0] dut_sram_read_address,
    input  logic [15:0] sram_dut_read_data,
    output logic        dut_sram_write_enable,
    output logic [11:0] dut_sram_write_address,
    output logic [15:0] dut_sram_write_data
);

    typedef enum logic [1:0] {IDLE, READ_HDR, STREAM, DONE} state_t;

    state_t state, state_nx;

    logic [2:0]         hdr_cnt;
    logic [11:0]        n_reg;
    logic [11:0]        in_cnt;
    logic signed [15:0] c0, c1, c2;
    logic signed [15:0] h1, h2;
    logic signed [15:0] x_in;
    logic               hdr_zero;
    logic               last_smp;

    logic signed [31:0] prod0_p0, prod1_p0, prod2_p0;
    logic [11:0]        idx_p0;
    logic               vld_p0;
    logic signed [33:0] sum_p1;

    // Clamp a 34-bit sum into the signed 16-bit output range.
    function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767)
            return 16'sh7FFF;
        else if (v < -34'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    assign x_in     = sram_dut_read_data;
    // Header word N arrives while hdr_cnt==1; an empty job skips streaming.
    assign hdr_zero = (hdr_cnt == 3'd1) && (sram_dut_read_data[11:0] == 12'd0);
    assign last_smp = (in_cnt == n_reg - 12'd1);
    assign sum_p1   = 34'(prod0_p0) + 34'(prod1_p0) + 34'(prod2_p0);

    // State register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; DONE drains the write pipeline before returning to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (dut_run) state_nx = READ_HDR;
            READ_HDR: begin
                if (hdr_zero)
                    state_nx = DONE;
                else if (hdr_cnt == 3'd4)
                    state_nx = STREAM;
            end
            STREAM:   if (last_smp) state_nx = DONE;
            DONE:     if (!vld_p0 && !dut_sram_write_enable) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Job control: read addressing, header capture and sample history.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            dut_busy              <= 1'b0;
            dut_sram_read_address <= 12'd0;
            hdr_cnt               <= 3'd0;
            in_cnt                <= 12'd0;
            n_reg                 <= 12'd0;
            c0                    <= 16'sd0;
            c1                    <= 16'sd0;
            c2                    <= 16'sd0;
            h1                    <= 16'sd0;
            h2                    <= 16'sd0;
        end else begin
            dut_busy <= (state_nx != IDLE);
            case (state)
                IDLE: begin
                    hdr_cnt               <= 3'd0;
                    in_cnt                <= 12'd0;
                    dut_sram_read_address <= 12'd0;
                    if (dut_run) begin
                        h1 <= 16'sd0;
                        h2 <= 16'sd0;
                    end
                end
                READ_HDR: begin
                    // Address k is driven while hdr_cnt==k; its data lands one cycle later.
                    hdr_cnt               <= hdr_cnt + 3'd1;
                    dut_sram_read_address <= dut_sram_read_address + 12'd1;
                    case (hdr_cnt)
                        3'd1:    n_reg <= sram_dut_read_data[11:0];
                        3'd2:    c0    <= x_in;
                        3'd3:    c1    <= x_in;
                        3'd4:    c2    <= x_in;
                        default: ;
                    endcase
                end
                STREAM: begin
                    // Every STREAM cycle delivers x[in_cnt].
                    in_cnt                <= in_cnt + 12'd1;
                    dut_sram_read_address <= dut_sram_read_address + 12'd1;
                    h1                    <= x_in;
                    h2                    <= h1;
                end
                DONE:    dut_sram_read_address <= 12'd0;
                default: ;
            endcase
        end
    end

    // Stage p0: the three tap products for the sample arriving this cycle.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            vld_p0   <= 1'b0;
            idx_p0   <= 12'd0;
            prod0_p0 <= 32'sd0;
            prod1_p0 <= 32'sd0;
            prod2_p0 <= 32'sd0;
        end else begin
            vld_p0 <= (state == STREAM);
            if (state == STREAM) begin
                idx_p0   <= in_cnt;
                prod0_p0 <= 32'(c0) * 32'(x_in);
                prod1_p0 <= 32'(c1) * 32'(h1);
                prod2_p0 <= 32'(c2) * 32'(h2);
            end
        end
    end

    // Stage p1: sum, saturate and present the output SRAM write.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            dut_sram_write_enable  <= 1'b0;
            dut_sram_write_address <= 12'd0;
            dut_sram_write_data    <= 16'd0;
        end else begin
            dut_sram_write_enable <= vld_p0;
            if (vld_p0) begin
                dut_sram_write_address <= idx_p0;
                dut_sram_write_data    <= sat16(sum_p1);
            end
        end
    end

endmodule

// File: tb/tb_my_design.sv
// Self-checking bench for my_design: SRAM models, a plain-arithmetic FIR
// reference, a table of directed jobs and randomized jobs with reset cases.
module tb_my_design;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        dut_run = 1'b0;
    logic        busy;
    logic [11:0] raddr;
    logic [15:0] rdata = 16'd0;
    logic        we;
    logic [11:0] waddr;
    logic [15:0] wdata;

    logic [15:0] imem [0:4095];
    logic [15:0] omem [0:4095];

    int wr_cnt  = 0;
    int oob_cnt = 0;
    int bad_we  = 0;
    int cur_n   = 0;
    int n_chk   = 0;
    int n_fail  = 0;

    typedef struct {
        int          n;
        logic [15:0] c0, c1, c2;
        int          kind;
        int          i0; logic [15:0] e0;
        int          i1; logic [15:0] e1;
        int          i2; logic [15:0] e2;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    my_design dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .dut_run                (dut_run),
        .dut_busy               (busy),
        .dut_sram_read_address  (raddr),
        .sram_dut_read_data     (rdata),
        .dut_sram_write_enable  (we),
        .dut_sram_write_address (waddr),
        .dut_sram_write_data    (wdata)
    );

    // Input SRAM with one-cycle registered read.
    always @(posedge clk) rdata <= imem[raddr];

    // Output SRAM plus write bookkeeping.
    always @(posedge clk) begin
        if (we) begin
            omem[waddr] <= wdata;
            wr_cnt      <= wr_cnt + 1;
            if (int'(waddr) >= cur_n) oob_cnt <= oob_cnt + 1;
        end
        if (we && !busy) bad_we <= bad_we + 1;
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sv16(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint xs(input int k);
        if (k < 0) return 0;
        return sv16(imem[4 + k]);
    endfunction

    // y[i] from the job description held in the input SRAM image.
    function automatic logic [15:0] ref_y(input int i);
        longint a;
        a = sv16(imem[1]) * xs(i) + sv16(imem[2]) * xs(i - 1) + sv16(imem[3]) * xs(i - 2);
        if (a > 32767) return 16'h7FFF;
        if (a < -32768) return 16'h8000;
        return 16'(a);
    endfunction

    function automatic logic [15:0] rnd16();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'h7FFF;
        if (r == 1) return 16'h8000;
        return 16'($urandom);
    endfunction

    task automatic load(input int n, input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] a2, input int kind);
        imem[0] = 16'(n);
        imem[1] = a0;
        imem[2] = a1;
        imem[3] = a2;
        for (int i = 0; i < n; i++) begin
            case (kind)
                0:       imem[4 + i] = 16'(i);
                1:       imem[4 + i] = 16'd1;
                2:       imem[4 + i] = 16'h7FFF;
                3:       imem[4 + i] = 16'h8000;
                default: imem[4 + i] = rnd16();
            endcase
        end
    endtask

    task automatic verify(input string tag, input int n, input int wr0, input int oob0);
        int          mism;
        int          fi;
        logic [15:0] fa, fe;
        mism = 0; fi = -1; fa = 16'd0; fe = 16'd0;
        for (int i = 0; i < n; i++) begin
            if (omem[i] !== ref_y(i)) begin
                if (mism == 0) begin fi = i; fa = omem[i]; fe = ref_y(i); end
                mism++;
            end
        end
        chk(mism == 0, $sformatf("%s_data@%0d", tag, fi), longint'(fa), longint'(fe));
        chk(wr_cnt - wr0 == n, {tag, "_write_count"}, wr_cnt - wr0, n);
        chk(oob_cnt - oob0 == 0, {tag, "_write_beyond_n"}, oob_cnt - oob0, 0);
    endtask

    // Waits (bounded) for busy to fall; lat counts negedges after the start edge.
    task automatic wait_done(input string tag, input int n, input bit glitch, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            dut_run = (glitch && lat < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
        end while (busy === 1'b1 && lat < n + 40);
        dut_run = 1'b0;
        chk(busy === 1'b0, {tag, "_busy_timeout"}, lat, n + 16);
    endtask

    task automatic do_job(input string tag, input int n, input bit glitch, output int lat);
        int wr0, oob0;
        @(negedge clk);
        cur_n = n; wr0 = wr_cnt; oob0 = oob_cnt;
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
        chk(busy === 1'b1, {tag, "_busy_rise"}, busy, 1);
        wait_done(tag, n, glitch, lat);
        chk(lat <= n + 16, {tag, "_latency"}, lat, n + 16);
        verify(tag, n, wr0, oob0);
    endtask

    initial begin
        int lat, wr0, oob0, n;

        tbl[0] = '{96,  16'd1,    16'd0,    16'd0,    0, 0, 16'd0,    50, 16'd50,   95,  16'd95};
        tbl[1] = '{3,   16'd1,    16'd1,    16'd1,    1, 0, 16'd1,    1,  16'd2,    2,   16'd3};
        tbl[2] = '{144, 16'd1,    16'd2,    16'd1,    1, 0, 16'd1,    1,  16'd3,    143, 16'd4};
        tbl[3] = '{4,   16'h7FFF, 16'h7FFF, 16'h7FFF, 2, 0, 16'h7FFF, 2,  16'h7FFF, 3,   16'h7FFF};
        tbl[4] = '{1,   16'h7FFF, 16'd0,    16'd0,    3, 0, 16'h8000, 0,  16'h8000, 0,   16'h8000};
        tbl[5] = '{2,   16'd2,    16'd3,    16'd5,    0, 0, 16'd0,    1,  16'd2,    1,   16'd2};

        // Reset state.
        repeat (3) @(negedge clk);
        chk(busy === 1'b0,   "reset_busy",  busy, 0);
        chk(we === 1'b0,     "reset_we",    we, 0);
        chk(raddr === 12'd0, "reset_raddr", raddr, 0);
        chk(waddr === 12'd0, "reset_waddr", waddr, 0);
        chk(wdata === 16'd0, "reset_wdata", wdata, 0);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table of jobs.
        for (int t = 0; t < 6; t++) begin
            load(tbl[t].n, tbl[t].c0, tbl[t].c1, tbl[t].c2, tbl[t].kind);
            do_job($sformatf("tbl%0d", t), tbl[t].n, 1'b0, lat);
            chk(omem[tbl[t].i0] === tbl[t].e0, $sformatf("tbl%0d_y%0d", t, tbl[t].i0), omem[tbl[t].i0], tbl[t].e0);
            chk(omem[tbl[t].i1] === tbl[t].e1, $sformatf("tbl%0d_y%0d", t, tbl[t].i1), omem[tbl[t].i1], tbl[t].e1);
            chk(omem[tbl[t].i2] === tbl[t].e2, $sformatf("tbl%0d_y%0d", t, tbl[t].i2), omem[tbl[t].i2], tbl[t].e2);
        end

        // Empty job: no writes, short busy pulse.
        load(0, 16'd5, 16'd6, 16'd7, 4);
        do_job("n0", 0, 1'b0, lat);
        chk(lat >= 1 && lat <= 8, "n0_busy_len", lat, 8);

        // Randomized jobs; the first toggles dut_run while busy.
        for (int j = 0; j < 5; j++) begin
            n = (j == 0) ? 40 : int'($urandom_range(3, 60));
            load(n, rnd16(), rnd16(), rnd16(), 4);
            do_job($sformatf("rnd%0d", j), n, j == 0, lat);
        end

        // Reset in the middle of a long job.
        load(96, rnd16(), rnd16(), rnd16(), 4);
        @(negedge clk);
        cur_n = 96;
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset_b = 1'b0;
        #1;
        chk(busy === 1'b0,   "midreset_busy",  busy, 0);
        chk(we === 1'b0,     "midreset_we",    we, 0);
        chk(waddr === 12'd0, "midreset_waddr", waddr, 0);
        wr0 = wr_cnt;
        repeat (3) @(negedge clk);
        chk(wr_cnt == wr0, "midreset_no_writes", wr_cnt - wr0, 0);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        chk(busy === 1'b0, "midreset_stays_idle", busy, 0);
        load(20, rnd16(), rnd16(), rnd16(), 4);
        do_job("post_reset", 20, 1'b0, lat);

        // dut_run held high across reset release.
        load(5, rnd16(), rnd16(), rnd16(), 4);
        @(negedge clk);
        reset_b = 1'b0;
        dut_run = 1'b1;
        cur_n = 5;
        @(negedge clk);
        wr0 = wr_cnt; oob0 = oob_cnt;
        reset_b = 1'b1;
        @(negedge clk);
        chk(busy === 1'b1, "run_at_release_busy", busy, 1);
        dut_run = 1'b0;
        wait_done("run_at_release", 5, 1'b0, lat);
        verify("run_at_release", 5, wr0, oob0);

        repeat (2) @(negedge clk);
        chk(bad_we == 0, "we_while_not_busy", bad_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/my_design.md
MY_DESIGN -- requirements
Module: my_design

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset_b  input  1  asynchronous, active-low reset.
REQ-004 dut_run  input  1  start request; level-sampled on rising clk.
REQ-005 dut_busy  output  1  high while a job is in progress.
REQ-006 dut_sram_read_address  output  12  input-SRAM word address.
REQ-007 sram_dut_read_data  input  16  input-SRAM read data.
REQ-008 dut_sram_write_enable  output  1  output-SRAM write strobe.
REQ-009 dut_sram_write_address  output  12  output-SRAM word address.
REQ-010 dut_sram_write_data  output  16  output-SRAM write data.

Function
REQ-011 SRAM read timing: data for an address driven in cycle t appears on sram_dut_read_data in cycle t+1 (registered read); the design shall pipeline reads accordingly.
REQ-012 Output SRAM writes the data/address pair on the rising edge where dut_sram_write_enable=1; one write per cycle maximum.
REQ-013 Input SRAM layout (per job): word 0 = N (unsigned, 0..4092); words 1,2,3 = coefficients c0,c1,c2 (signed 16-bit two's complement); words 4..N+3 = samples x[0..N-1] (signed 16-bit).
REQ-014 Result: y[i] = c0*x[i] + c1*x[i-1] + c2*x[i-2], with x[-1]=x[-2]=0; products and sum in 34-bit signed arithmetic, no intermediate overflow.
REQ-015 Each y[i] shall be saturated to signed 16-bit (>32767 -> 0x7FFF, <-32768 -> 0x8000) and written to output address i, for i=0..N-1, in ascending address order.
REQ-016 States: IDLE, READ_HDR (N and coefficients), STREAM (sample read/compute/write), DONE.
REQ-017 IDLE -> READ_HDR on a rising edge with dut_run=1; dut_busy shall go high on that edge (visible the following cycle).
REQ-018 dut_run is ignored while dut_busy=1; the job is not restarted or aborted by run activity.
REQ-019 STREAM shall sustain one sample read and one result write per cycle after pipeline fill.
REQ-020 DONE: after the final write (y[N-1]) is committed, dut_busy shall drop to 0 on the next edge and the FSM returns to IDLE.
REQ-021 Latency: dut_run sampled -> dut_busy low in at most N+16 clock cycles.
REQ-022 N=0: no output writes; dut_busy high for at least 1 and at most 8 cycles, then low.
REQ-023 N=1 and N=2: zero-history rule of REQ-014 applies; exactly N writes.
REQ-024 Output SRAM addresses >= N shall never be written by a job.
REQ-025 dut_sram_write_enable shall be 0 in every cycle outside STREAM/flush and whenever dut_busy=0.
REQ-026 Back-to-back jobs: a new dut_run after dut_busy falls starts a fresh job; all internal history (x[i-1], x[i-2]) cleared at job start.

Reset
REQ-027 While reset_b=0 (asynchronously): FSM=IDLE, dut_busy=0, dut_sram_write_enable=0, dut_sram_read_address=0, dut_sram_write_address=0, dut_sram_write_data=0, all history/coefficient registers 0.
REQ-028 Reset asserted mid-job aborts immediately; no further writes; after release the design waits in IDLE for dut_run.
REQ-029 dut_run held high across reset release shall start a job on the first rising edge after release.

Verification
REQ-030 N=96, c=(1,0,0), x[i]=i -> output addr 0..95 = 0..95; busy falls within 112 cycles of run.
REQ-031 N=144, c=(1,2,1), x[i]=1 -> y[0]=1, y[1]=3, y[2..143]=4; exactly 144 writes, none at addr >=144.
REQ-032 N=4, c=(0x7FFF,0x7FFF,0x7FFF), x=(0x7FFF x4) -> all outputs 0x7FFF; c0=0x7FFF, x=(0x8000) N=1 -> 0x8000.
REQ-033 N=0 -> no write strobes; busy pulses 1..8 cycles then returns low.
REQ-034 Assert reset_b=0 at cycle 20 of an N=96 job -> busy and write_enable 0 immediately; new run completes a clean job with correct results.
REQ-035 Two sequential jobs (second with different c and N=3) -> second job results independent of first job's history.
